// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised integer register file with dual write, bypass and scoreboard
module regfile_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_ena0,
    input  logic [AW-1:0]        w_addr0,
    input  logic [XLEN-1:0]      w_data0,
    input  logic                 w_ena1,
    input  logic [AW-1:0]        w_addr1,
    input  logic [XLEN-1:0]      w_data1,
    input  logic [NRD-1:0]       r_ena,
    input  logic [NRD*AW-1:0]    r_addr,
    output logic [NRD*XLEN-1:0]  r_data,
    output logic [NRD-1:0]       r_busy,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_addr,
    input  logic                 sb_clr0,
    input  logic                 sb_clr1,
    output logic [AW:0]          busy_cnt,
    output logic [NREG*XLEN-1:0] regs_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] set_vec, clr_vec;
    logic [AW:0]     cnt_q, cnt_d;
    logic            up, down0, down1;

    // Post-write view of every register; port 1 is applied last so it wins a collision.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (w_ena0 && (w_addr0 == AW'(i))) regs_d[i] = w_data0;
            if (w_ena1 && (w_addr1 == AW'(i))) regs_d[i] = w_data1;
        end
        regs_d[0] = '0;
    end

    // Scoreboard next state: set beats clear, and the count moves only by the bits that flip.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (sb_set)  set_vec[sb_addr] = 1'b1;
        if (sb_clr0) clr_vec[w_addr0] = 1'b1;
        if (sb_clr1) clr_vec[w_addr1] = 1'b1;
        set_vec[0] = 1'b0;
        clr_vec[0] = 1'b0;
        busy_d     = set_vec | (busy_q & ~clr_vec);
        busy_d[0]  = 1'b0;
        up    = set_vec[sb_addr] & ~busy_q[sb_addr];
        down0 = sb_clr0 & clr_vec[w_addr0] & busy_q[w_addr0] & ~set_vec[w_addr0];
        // Both clears on one register only retire it once.
        down1 = sb_clr1 & clr_vec[w_addr1] & busy_q[w_addr1] & ~set_vec[w_addr1]
              & ~(sb_clr0 && (w_addr0 == w_addr1));
        cnt_d = cnt_q + {{AW{1'b0}}, up} - {{AW{1'b0}}, down0} - {{AW{1'b0}}, down1};
    end

    // Read ports and difftest snapshot; everything reads as zero while reset is held.
    always_comb begin
        r_data = '0;
        r_busy = '0;
        regs_o = '0;
        for (int k = 0; k < NRD; k++) begin
            if (!rst && r_ena[k] && (r_addr[k*AW +: AW] != '0)) begin
                r_data[k*XLEN +: XLEN] = regs_d[r_addr[k*AW +: AW]];
                r_busy[k] = busy_q[r_addr[k*AW +: AW]] & ~clr_vec[r_addr[k*AW +: AW]];
            end
        end
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_o[i*XLEN +: XLEN] = regs_d[i];
            end
        end
    end

    assign busy_cnt = cnt_q;

    // State registers; reset discards any same-cycle write, set or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
